sctrl_mc: RTL and testbench
===========================

SCTRL_MC -- requirements
Module: sctrl_mc

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; low forces reset state immediately, independent of clk.
REQ-003 OPcode  input  6  instruction bits [31:26] from instruction register.
REQ-004 Fun  input  6  instruction bits [5:0] (R-type function).
REQ-005 zero  input  1  ALU zero flag from datapath.
REQ-006 overflow  input  1  ALU signed-overflow flag from datapath.
REQ-007 MIO_ready  input  1  memory/IO handshake; high = access completes this cycle.
REQ-008 PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite  output  1 each  multi-cycle datapath strobes.
REQ-009 ALUSrc_A  output  1  0 = PC, 1 = rs.
REQ-010 ALUSrc_B  output  2  00 rt, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-011 ALU_Control  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 100 nor, 101 srl, 011 xor.
REQ-012 RegDst, RegWrite, Jal  output  1 each  dest = rd/rt; register-file write; force dest = $31.
REQ-013 DatatoReg  output  2  00 ALU, 01 memory, 10 lui (imm<<16), 11 PC.
REQ-014 Branch  output  2  PC source: 00 ALU result, 01 ALU-out register, 10 jump target, 11 rs (jr).
REQ-015 state_out  output  4  current state code, debug.
REQ-016 ovf_flag  output  1  sticky overflow trap indicator (see Configuration).

Function
REQ-017 States (code): IF 0, ID 1, MA 2 (mem addr), LW_RD 3, LW_WB 4, SW_WR 5, R_EX 6, R_WB 7, BR 8, I_EX 9, I_WB 10, JMP 11, JAL 12, JR 13; codes 14-15 unreachable, decode to IF on next edge.
REQ-018 All outputs Moore-decoded from state except PCWrite/IRWrite in IF and MIO-gated strobes (REQ-019, REQ-020).
REQ-019 IF: MemRead=1, IorD=0, ALUSrc_A=0, ALUSrc_B=01, ALU_Control=010, Branch=00; IRWrite and PCWrite asserted only while MIO_ready=1; stay in IF until MIO_ready=1, then go to ID.
REQ-020 LW_RD and SW_WR: IorD=1, MemRead / MemWrite held until MIO_ready=1; advance on that cycle only.
REQ-021 ID: ALUSrc_A=0, ALUSrc_B=11, ALU_Control=010 (branch target precompute); next state by OPcode: 000000 -> R_EX (Fun 001000 -> JR); 100011/101011 -> MA; 000100/000101 -> BR; 001000/001100/001101/001010/001110/001111 -> I_EX; 000010 -> JMP; 000011 -> JAL; any other -> IF with no write (illegal opcode is a NOP).
REQ-022 R_EX: ALUSrc_A=1, ALUSrc_B=00, ALU_Control from Fun (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 100111 nor, 000010 srl, 100110 xor; other -> add). R_WB: RegDst=1, RegWrite=1, DatatoReg=00.
REQ-023 BR: ALU_Control=110, ALUSrc_A=1, ALUSrc_B=00, Branch=01; PCWrite=1 iff (beq and zero=1) or (bne and zero=0); next IF.
REQ-024 I_EX: ALUSrc_B=10; addi 010, andi 000, ori 001, slti 111, xori 011; lui -> I_WB with DatatoReg=10. I_WB: RegDst=0, RegWrite=1.
REQ-025 JMP: PCWrite=1, Branch=10. JAL: PCWrite=1, Branch=10, RegWrite=1, Jal=1, DatatoReg=11. JR: PCWrite=1, Branch=11. All return to IF.
REQ-026 Every instruction ends in IF; latency: jump/branch 3 cycles, R/I 4, sw 4, lw 5 (excluding MIO_ready wait cycles).
REQ-027 Default for every strobe not listed in a state is 0; ALUSrc_B default 00, ALU_Control default 010.

Reset
REQ-028 rst=0 asynchronously forces state IF, clears ovf_flag, and drives all outputs to IF values with IRWrite/PCWrite low until rst=1.
REQ-029 Reset mid-access (LW_RD/SW_WR) abandons the access; MemWrite drops in the same instant.

Configuration
REQ-030 Macro SCTRL_OVF_TRAP_EN: defined -> in R_WB/I_WB for add, sub, addi, if overflow=1 RegWrite is suppressed and ovf_flag set, held until reset; undefined -> write proceeds unchanged and ovf_flag tied 0.

Verification
REQ-031 rst low 3 cycles, MIO_ready=1 -> state_out=0, ovf_flag=0, after release IRWrite=PCWrite=1 in first cycle.
REQ-032 IF with MIO_ready=0 for 4 cycles -> state_out stays 0, IRWrite=0; fifth cycle MIO_ready=1 -> IRWrite=1, next state 1.
REQ-033 OPcode=000000, Fun=100000 -> states 0,1,6,7,0; ALU_Control=010 in 6; RegDst=1, RegWrite=1 in 7.
REQ-034 OPcode=100011 -> states 0,1,2,3,4,0; LW_WB DatatoReg=01, RegDst=0, RegWrite=1.
REQ-035 OPcode=000100 with zero=1 -> PCWrite=1, Branch=01 in state 8; with zero=0 -> PCWrite=0.
REQ-036 SCTRL_OVF_TRAP_EN defined, add with overflow=1 -> RegWrite=0 in state 7, ovf_flag=1 persists until rst=0.

Source files
------------

// File: rtl/sctrl_mc.sv
// Multi-cycle MIPS control unit: Moore FSM driving datapath strobes, with MIO_ready handshake.
// Optional overflow trap on add/sub/addi writeback enabled by defining SCTRL_OVF_TRAP_EN.
module sctrl_mc (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OPcode,
  input  logic [5:0] Fun,
  input  logic       zero,
  input  logic       overflow,
  input  logic       MIO_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       ALUSrc_A,
  output logic [1:0] ALUSrc_B,
  output logic [2:0] ALU_Control,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       Jal,
  output logic [1:0] DatatoReg,
  output logic [1:0] Branch,
  output logic [3:0] state_out,
  output logic       ovf_flag
);

  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_MA = 4'd2, S_LW_RD = 4'd3, S_LW_WB = 4'd4,
    S_SW_WR = 4'd5, S_R_EX = 4'd6, S_R_WB = 4'd7, S_BR = 4'd8, S_I_EX = 4'd9,
    S_I_WB = 4'd10, S_JMP = 4'd11, S_JAL = 4'd12, S_JR = 4'd13
  } state_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010, OP_XORI = 6'b001110, OP_LUI = 6'b001111;
  localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_JR = 6'b001000;

`ifdef SCTRL_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t state, next_state;
  logic   trap;

  function automatic logic [2:0] fun_alu(input logic [5:0] f);
    case (f)
      6'b100010: fun_alu = 3'b110;
      6'b100100: fun_alu = 3'b000;
      6'b100101: fun_alu = 3'b001;
      6'b101010: fun_alu = 3'b111;
      6'b100111: fun_alu = 3'b100;
      6'b000010: fun_alu = 3'b101;
      6'b100110: fun_alu = 3'b011;
      default:   fun_alu = 3'b010;
    endcase
  endfunction

  function automatic logic [2:0] imm_alu(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_alu = 3'b000;
      OP_ORI:  imm_alu = 3'b001;
      OP_SLTI: imm_alu = 3'b111;
      OP_XORI: imm_alu = 3'b011;
      default: imm_alu = 3'b010;
    endcase
  endfunction

  // Only signed add/sub/addi can trap; the ALU flag is still valid in writeback.
  assign trap = TRAP_EN & overflow &
                (((state == S_R_WB) && (OPcode == OP_R) && ((Fun == FN_ADD) || (Fun == FN_SUB))) ||
                 ((state == S_I_WB) && (OPcode == OP_ADDI)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IF;
    else      state <= next_state;
  end

`ifdef SCTRL_OVF_TRAP_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      ovf_q <= 1'b0;
    else if (trap) ovf_q <= 1'b1;
  end
  assign ovf_flag = ovf_q;
`else
  assign ovf_flag = 1'b0;
`endif

  assign state_out = state;

  always_comb begin
    next_state  = S_IF;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    ALUSrc_A    = 1'b0;
    ALUSrc_B    = 2'b00;
    ALU_Control = 3'b010;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    Jal         = 1'b0;
    DatatoReg   = 2'b00;
    Branch      = 2'b00;
    case (state)
      S_IF: begin
        MemRead  = 1'b1;
        ALUSrc_B = 2'b01;
        // Gate with rst so fetch strobes stay low while reset is held.
        IRWrite  = MIO_ready & rst;
        PCWrite  = MIO_ready & rst;
        next_state = MIO_ready ? S_ID : S_IF;
      end
      S_ID: begin
        ALUSrc_B = 2'b11;
        case (OPcode)
          OP_R:                                            next_state = (Fun == FN_JR) ? S_JR : S_R_EX;
          OP_LW, OP_SW:                                    next_state = S_MA;
          OP_BEQ, OP_BNE:                                  next_state = S_BR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI, OP_LUI: next_state = S_I_EX;
          OP_J:                                            next_state = S_JMP;
          OP_JAL:                                          next_state = S_JAL;
          default:                                         next_state = S_IF;
        endcase
      end
      S_MA: begin
        ALUSrc_A   = 1'b1;
        ALUSrc_B   = 2'b10;
        next_state = (OPcode == OP_LW) ? S_LW_RD : S_SW_WR;
      end
      S_LW_RD: begin
        IorD       = 1'b1;
        MemRead    = 1'b1;
        next_state = MIO_ready ? S_LW_WB : S_LW_RD;
      end
      S_LW_WB: begin
        RegWrite  = 1'b1;
        DatatoReg = 2'b01;
      end
      S_SW_WR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        next_state = MIO_ready ? S_IF : S_SW_WR;
      end
      S_R_EX: begin
        ALUSrc_A    = 1'b1;
        ALU_Control = fun_alu(Fun);
        next_state  = S_R_WB;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = ~trap;
      end
      S_BR: begin
        ALUSrc_A    = 1'b1;
        ALU_Control = 3'b110;
        Branch      = 2'b01;
        PCWrite     = ((OPcode == OP_BEQ) & zero) | ((OPcode == OP_BNE) & ~zero);
      end
      S_I_EX: begin
        ALUSrc_A    = 1'b1;
        ALUSrc_B    = 2'b10;
        ALU_Control = imm_alu(OPcode);
        next_state  = S_I_WB;
      end
      S_I_WB: begin
        RegWrite  = ~trap;
        DatatoReg = (OPcode == OP_LUI) ? 2'b10 : 2'b00;
      end
      S_JMP: begin
        PCWrite = 1'b1;
        Branch  = 2'b10;
      end
      S_JAL: begin
        PCWrite   = 1'b1;
        Branch    = 2'b10;
        RegWrite  = 1'b1;
        Jal       = 1'b1;
        DatatoReg = 2'b11;
      end
      S_JR: begin
        PCWrite = 1'b1;
        Branch  = 2'b11;
      end
      default: next_state = S_IF;
    endcase
  end

endmodule

// File: tb/tb_sctrl_mc.sv
// Table-driven bench for sctrl_mc: per-instruction state walks with one output snapshot,
// plus hand sequences for reset, MIO_ready stalls, mid-access reset and overflow trap.
module tb_sctrl_mc;

`ifdef SCTRL_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] OPcode = 6'h3F, Fun = 6'h00;
  logic       zero = 1'b0, overflow = 1'b0, MIO_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, ALUSrc_A;
  logic [1:0] ALUSrc_B, DatatoReg, Branch;
  logic [2:0] ALU_Control;
  logic       RegDst, RegWrite, Jal, ovf_flag;
  logic [3:0] state_out;

  always #5 clk = ~clk;

  sctrl_mc dut (
    .clk(clk), .rst(rst), .OPcode(OPcode), .Fun(Fun), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrc_A(ALUSrc_A),
    .ALUSrc_B(ALUSrc_B), .ALU_Control(ALU_Control), .RegDst(RegDst), .RegWrite(RegWrite),
    .Jal(Jal), .DatatoReg(DatatoReg), .Branch(Branch), .state_out(state_out), .ovf_flag(ovf_flag)
  );

  typedef struct packed {
    logic pcw, pcwc, iord, irw, mrd, mwr, asa;
    logic [1:0] asb;
    logic [2:0] alu;
    logic rdst, rw, jal;
    logic [1:0] d2r, br;
  } outs_t;

  typedef struct packed {
    logic [5:0] op, fun;
    logic z, ovf;
    logic [2:0] len;
    logic [0:5][3:0] seq;
    logic [3:0] cs;
    outs_t exp;
  } vec_t;

  outs_t act;
  assign act = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, ALUSrc_A, ALUSrc_B,
                ALU_Control, RegDst, RegWrite, Jal, DatatoReg, Branch};

  int ntests = 0;
  int nfail  = 0;
  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    ntests++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
    end
  endtask

  function automatic outs_t mk(input logic pcw, iord, irw, mrd, mwr, asa,
                               input logic [1:0] asb, input logic [2:0] alu,
                               input logic rdst, rw, jal, input logic [1:0] d2r, br);
    mk = {pcw, 1'b0, iord, irw, mrd, mwr, asa, asb, alu, rdst, rw, jal, d2r, br};
  endfunction

  function automatic void add(input logic [5:0] op, fun, input logic z, o, input logic [2:0] n,
                              input logic [0:5][3:0] s, input logic [3:0] cs, input outs_t e);
    vec_t v;
    v.op = op; v.fun = fun; v.z = z; v.ovf = o; v.len = n; v.seq = s; v.cs = cs; v.exp = e;
    vq.push_back(v);
  endfunction

  // Starts with the DUT in IF at negedge; ends back in IF at negedge.
  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    OPcode = v.op; Fun = v.fun; zero = v.z; overflow = v.ovf; MIO_ready = 1'b1;
    for (int k = 0; k < int'(v.len); k++) begin
      if (k > 0) @(negedge clk);
      #1;
      nm = $sformatf("vec%0d_state%0d", idx, k);
      chk(nm, {28'd0, state_out}, {28'd0, v.seq[k]});
      if (state_out == v.cs && v.seq[k] == v.cs) begin
        nm = $sformatf("vec%0d_outs_s%0d", idx, v.cs);
        chk(nm, {13'd0, act}, {13'd0, v.exp});
      end
    end
  endtask

  task automatic step_state(input string name, input logic [3:0] e);
    @(negedge clk); #1;
    chk(name, {28'd0, state_out}, {28'd0, e});
  endtask

  initial begin
    // R-type ALU decode in R_EX and writeback
    add(6'h00, 6'h20, 0, 0, 5, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 4'd6, mk(0,0,0,0,0,1,2'b00,3'b010,0,0,0,2'b00,2'b00));
    add(6'h00, 6'h20, 0, 0, 5, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 4'd7, mk(0,0,0,0,0,0,2'b00,3'b010,1,1,0,2'b00,2'b00));
    add(6'h00, 6'h22, 0, 0, 5, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 4'd6, mk(0,0,0,0,0,1,2'b00,3'b110,0,0,0,2'b00,2'b00));
    add(6'h00, 6'h24, 0, 0, 5, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 4'd6, mk(0,0,0,0,0,1,2'b00,3'b000,0,0,0,2'b00,2'b00));
    add(6'h00, 6'h25, 0, 0, 5, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 4'd6, mk(0,0,0,0,0,1,2'b00,3'b001,0,0,0,2'b00,2'b00));
    add(6'h00, 6'h2A, 0, 0, 5, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 4'd6, mk(0,0,0,0,0,1,2'b00,3'b111,0,0,0,2'b00,2'b00));
    add(6'h00, 6'h27, 0, 0, 5, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 4'd6, mk(0,0,0,0,0,1,2'b00,3'b100,0,0,0,2'b00,2'b00));
    add(6'h00, 6'h02, 0, 0, 5, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 4'd6, mk(0,0,0,0,0,1,2'b00,3'b101,0,0,0,2'b00,2'b00));
    add(6'h00, 6'h26, 0, 0, 5, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 4'd6, mk(0,0,0,0,0,1,2'b00,3'b011,0,0,0,2'b00,2'b00));
    add(6'h00, 6'h3F, 0, 0, 5, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 4'd6, mk(0,0,0,0,0,1,2'b00,3'b010,0,0,0,2'b00,2'b00));
    // IF and ID snapshots
    add(6'h00, 6'h20, 0, 0, 5, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 4'd0, mk(1,0,1,1,0,0,2'b01,3'b010,0,0,0,2'b00,2'b00));
    add(6'h3F, 6'h00, 0, 0, 3, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}, 4'd1, mk(0,0,0,0,0,0,2'b11,3'b010,0,0,0,2'b00,2'b00));
    // load / store
    add(6'h23, 6'h00, 0, 0, 6, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 4'd2, mk(0,0,0,0,0,1,2'b10,3'b010,0,0,0,2'b00,2'b00));
    add(6'h23, 6'h00, 0, 0, 6, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 4'd3, mk(0,1,0,1,0,0,2'b00,3'b010,0,0,0,2'b00,2'b00));
    add(6'h23, 6'h00, 0, 0, 6, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 4'd4, mk(0,0,0,0,0,0,2'b00,3'b010,0,1,0,2'b01,2'b00));
    add(6'h2B, 6'h00, 0, 0, 5, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0}, 4'd5, mk(0,1,0,0,1,0,2'b00,3'b010,0,0,0,2'b00,2'b00));
    // branches, both polarities of zero
    add(6'h04, 6'h00, 1, 0, 4, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0}, 4'd8, mk(1,0,0,0,0,1,2'b00,3'b110,0,0,0,2'b00,2'b01));
    add(6'h04, 6'h00, 0, 0, 4, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0}, 4'd8, mk(0,0,0,0,0,1,2'b00,3'b110,0,0,0,2'b00,2'b01));
    add(6'h05, 6'h00, 0, 0, 4, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0}, 4'd8, mk(1,0,0,0,0,1,2'b00,3'b110,0,0,0,2'b00,2'b01));
    add(6'h05, 6'h00, 1, 0, 4, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0}, 4'd8, mk(0,0,0,0,0,1,2'b00,3'b110,0,0,0,2'b00,2'b01));
    // jumps
    add(6'h02, 6'h00, 0, 0, 4, {4'd0, 4'd1, 4'd11, 4'd0, 4'd0, 4'd0}, 4'd11, mk(1,0,0,0,0,0,2'b00,3'b010,0,0,0,2'b00,2'b10));
    add(6'h03, 6'h00, 0, 0, 4, {4'd0, 4'd1, 4'd12, 4'd0, 4'd0, 4'd0}, 4'd12, mk(1,0,0,0,0,0,2'b00,3'b010,0,1,1,2'b11,2'b10));
    add(6'h00, 6'h08, 0, 0, 4, {4'd0, 4'd1, 4'd13, 4'd0, 4'd0, 4'd0}, 4'd13, mk(1,0,0,0,0,0,2'b00,3'b010,0,0,0,2'b00,2'b11));
    // immediates
    add(6'h08, 6'h00, 0, 0, 5, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd0}, 4'd9, mk(0,0,0,0,0,1,2'b10,3'b010,0,0,0,2'b00,2'b00));
    add(6'h0C, 6'h00, 0, 0, 5, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd0}, 4'd9, mk(0,0,0,0,0,1,2'b10,3'b000,0,0,0,2'b00,2'b00));
    add(6'h0D, 6'h00, 0, 0, 5, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd0}, 4'd9, mk(0,0,0,0,0,1,2'b10,3'b001,0,0,0,2'b00,2'b00));
    add(6'h0A, 6'h00, 0, 0, 5, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd0}, 4'd9, mk(0,0,0,0,0,1,2'b10,3'b111,0,0,0,2'b00,2'b00));
    add(6'h0E, 6'h00, 0, 0, 5, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd0}, 4'd9, mk(0,0,0,0,0,1,2'b10,3'b011,0,0,0,2'b00,2'b00));
    add(6'h0F, 6'h00, 0, 0, 5, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd0}, 4'd10, mk(0,0,0,0,0,0,2'b00,3'b010,0,1,0,2'b10,2'b00));
    // ori overflow is never a trap candidate
    add(6'h0D, 6'h00, 0, 1, 5, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd0}, 4'd10, mk(0,0,0,0,0,0,2'b00,3'b010,0,1,0,2'b00,2'b00));

    // reset held 3 cycles
    rst = 1'b0; MIO_ready = 1'b1; OPcode = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_state", {28'd0, state_out}, 32'd0);
    end
    chk("rst_ovf", {31'd0, ovf_flag}, 32'd0);
    chk("rst_irwrite", {31'd0, IRWrite}, 32'd0);
    chk("rst_pcwrite", {31'd0, PCWrite}, 32'd0);
    chk("rst_memread", {31'd0, MemRead}, 32'd1);
    rst = 1'b1; #1;
    chk("rel_irwrite", {31'd0, IRWrite}, 32'd1);
    chk("rel_pcwrite", {31'd0, PCWrite}, 32'd1);
    step_state("rel_id", 4'd1);
    step_state("rel_if", 4'd0);

    for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

    // fetch stall: MIO_ready low for 4 cycles
    MIO_ready = 1'b0; OPcode = 6'h3F;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_state", {28'd0, state_out}, 32'd0);
      chk("stall_irwrite", {31'd0, IRWrite}, 32'd0);
      @(negedge clk);
    end
    MIO_ready = 1'b1; #1;
    chk("stall_irwrite_go", {31'd0, IRWrite}, 32'd1);
    step_state("stall_next_id", 4'd1);
    step_state("stall_back_if", 4'd0);

    // load stalled in LW_RD
    OPcode = 6'h23;
    step_state("lwst_id", 4'd1);
    step_state("lwst_ma", 4'd2);
    MIO_ready = 1'b0;
    step_state("lwst_rd0", 4'd3);
    step_state("lwst_rd1", 4'd3);
    chk("lwst_memread", {31'd0, MemRead}, 32'd1);
    MIO_ready = 1'b1;
    step_state("lwst_wb", 4'd4);
    step_state("lwst_if", 4'd0);

    // reset during a stalled store abandons it at once
    OPcode = 6'h2B;
    step_state("swrst_id", 4'd1);
    step_state("swrst_ma", 4'd2);
    MIO_ready = 1'b0;
    step_state("swrst_wr", 4'd5);
    chk("swrst_memwrite_on", {31'd0, MemWrite}, 32'd1);
    #2 rst = 1'b0; #1;
    chk("swrst_memwrite_off", {31'd0, MemWrite}, 32'd0);
    chk("swrst_async_state", {28'd0, state_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1; MIO_ready = 1'b1; OPcode = 6'h3F; #1;
    chk("swrst_hold_if", {28'd0, state_out}, 32'd0);
    step_state("swrst_id2", 4'd1);
    step_state("swrst_if2", 4'd0);

    // overflow on add
    OPcode = 6'h00; Fun = 6'h20; overflow = 1'b1;
    step_state("ovf_id", 4'd1);
    step_state("ovf_rex", 4'd6);
    step_state("ovf_rwb", 4'd7);
    chk("ovf_regwrite", {31'd0, RegWrite}, {31'd0, !TRAP});
    step_state("ovf_if", 4'd0);
    overflow = 1'b0; OPcode = 6'h3F;
    chk("ovf_flag_set", {31'd0, ovf_flag}, {31'd0, TRAP});
    step_state("ovf_id2", 4'd1);
    step_state("ovf_if2", 4'd0);
    chk("ovf_flag_sticky", {31'd0, ovf_flag}, {31'd0, TRAP});
    rst = 1'b0; #1;
    chk("ovf_flag_clr", {31'd0, ovf_flag}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
